mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Parametrised multi-cycle control unit for the RV32I multi-cycle CPU. It sequences each instruction through IF/ID/EX/MEM/WB with a registered state machine and waits on ready/request handshakes to instruction and data memory. Write enables are gated per state, memory stalls are guarded by a timeout, and illegal or SYSTEM opcodes drive sticky TRAP and HALT states. It also keeps a retired-instruction counter. It sits between the instruction register and the datapath muxes and enables.

## Interface
- TIMEOUT_CYCLES, 16: max wait cycles for a memory ready; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- opcode  in  7  instruction register [6:0]; valid from ID onward.
- funct3  in  3  instruction register [14:12].
- I_MEM_READY  in  1  instruction fetch complete; qualifies IMemReq.
- D_MEM_READY  in  1  data access complete; qualifies DMemReq.
- State  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, TRAP=6.
- IMemReq, IRWrite  out  1  fetch request; IR load strobe.
- DMemReq, MemWrite  out  1  data request; store enable.
- PCWrite  out  1  PC update strobe (the final cycle of each instruction).
- Branch, Jump, JALorJALR  out  1  PC source select.
- RegWrite, MemtoReg, ALUSrc1, ALUSrc2  out  1  datapath controls.
- ALUOp  out  7  equals opcode.
- BE  out  4  byte enables.
- Concat_control  out  3  immediate format select.
- HALTED, ILLEGAL, TIMEOUT  out  1  sticky status flags.
- INSTR_CNT  out  CNT_W  retired-instruction count.

## Operation
- Decode: opcode classes are LUI 0110111, AUIPC 0010111, R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, SYSTEM 1110011.
- Static controls (MemtoReg, ALUSrc1/2, JALorJALR, Concat_control, BE, Branch, Jump) decode combinationally from opcode/funct3.
  - Concat_control: U-type=001, R=000, I=011, shift-immediate (funct3 001/101)=110, LOAD=011, STORE=101, BRANCH=100, JAL=010, JALR=011.
  - BE for LOAD/STORE: funct3 x00=0001, x01=0011, 010=1111; other funct3 values give 0000.
  - Unused controls are driven 0, never x.
- Transitions:
  - IF: IMemReq=1. On I_MEM_READY, IRWrite=1 that cycle, then go to ID.
  - ID: a legal class goes to EX. SYSTEM goes to HALT and sets HALTED. Any other opcode goes to TRAP and sets ILLEGAL.
  - EX:
    - R/I/LUI/AUIPC/JAL/JALR go to WB.
    - LOAD/STORE go to MEM.
    - BRANCH asserts PCWrite (with Branch=1; the datapath resolves the target or PC+4) and goes to IF.
  - MEM: DMemReq=1; MemWrite=1 for STORE. On D_MEM_READY, LOAD goes to WB; STORE asserts PCWrite and goes to IF.
  - WB: RegWrite=1, PCWrite=1, then go to IF.
  - HALT, TRAP: absorbing. All strobes stay 0 until reset.
- Gating: RegWrite, MemWrite, PCWrite, IRWrite, IMemReq and DMemReq are 0 outside the states listed above.
- Timeout (TIMEOUT_CYCLES>0):
  - A wait counter clears on entry to IF or MEM.
  - It increments each cycle the request is held without ready.
  - When it reaches TIMEOUT_CYCLES-1 with ready still low, the next state is TRAP and TIMEOUT is set.
  - Ready in that same cycle wins: normal transition, no timeout.
- INSTR_CNT increments by 1 on each PCWrite and wraps modulo 2^CNT_W.

## Timing
- Reset (RSTn low, asynchronous): State=IF, INSTR_CNT=0, wait counter=0, status flags=0.
  - While RSTn is low, every strobe output is 0.
  - After release, IMemReq asserts in the first IF cycle.
- Reset mid-instruction aborts it immediately. No further strobes are issued.
- Latency with zero-wait memory (ready in the request cycle): R/I/U/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Each wait cycle adds 1.
- State and flags are registered. Strobes are combinational from State, decode, and ready.
- PCWrite is exactly one cycle per retired instruction.

## Test plan
- ADD (0110011), ready tied high → States 0,1,2,4; RegWrite and PCWrite high only in cycle 4; INSTR_CNT 0→1.
- LW funct3=010, D_MEM_READY delayed 3 cycles → MEM held 4 cycles with DMemReq=1, BE=1111, then WB; total 8 cycles.
- SB then BEQ → SB: MemWrite=1 only in MEM, BE=0001, PCWrite on ready, no RegWrite. BEQ: PCWrite and Branch in EX; 3 cycles.
- Opcode 0000000 → TRAP, ILLEGAL=1, no strobes for 20 cycles; RSTn pulse low returns State=IF and clears flags.
- TIMEOUT_CYCLES=4, I_MEM_READY held low → TRAP after 4 IF cycles with TIMEOUT=1. Repeat with ready in the 4th cycle → ID, no timeout.
- CNT_W=3, nine ADDs → INSTR_CNT wraps to 1; a SYSTEM opcode then gives HALTED=1 and the count freezes.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: instruction fields and memory ready handshakes in, datapath strobes,
// selects and status out. The FSM uses the slave modport; the datapath/bench uses master.
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             i_mem_ready;
    logic             d_mem_ready;
    logic [2:0]       state;
    logic             i_mem_req;
    logic             ir_write;
    logic             d_mem_req;
    logic             mem_write;
    logic             pc_write;
    logic             branch;
    logic             jump;
    logic             jal_or_jalr;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src1;
    logic             alu_src2;
    logic [6:0]       alu_op;
    logic [3:0]       be;
    logic [2:0]       concat_control;
    logic             halted;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] instr_cnt;

    modport slave (
        input  opcode, funct3, i_mem_ready, d_mem_ready,
        output state, i_mem_req, ir_write, d_mem_req, mem_write, pc_write, branch, jump,
               jal_or_jalr, reg_write, mem_to_reg, alu_src1, alu_src2, alu_op, be,
               concat_control, halted, illegal, timeout, instr_cnt
    );

    modport master (
        output opcode, funct3, i_mem_ready, d_mem_ready,
        input  state, i_mem_req, ir_write, d_mem_req, mem_write, pc_write, branch, jump,
               jal_or_jalr, reg_write, mem_to_reg, alu_src1, alu_src2, alu_op, be,
               concat_control, halted, illegal, timeout, instr_cnt
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: IF/ID/EX/MEM/WB sequencing with memory handshakes,
// stall timeout, sticky HALT/TRAP states and a retired-instruction counter.
module mc_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    mc_control_fsm_if.slave  bus_io
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam int unsigned      WaitW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitMax   = WaitW'(TIMEOUT_CYCLES - 1);
    localparam bit               TimeoutEn = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5,
        StTrap = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             halted_q, halted_d, illegal_q, illegal_d, timeout_q, timeout_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       i_rdy, d_rdy;
    logic       is_load, is_store, is_branch, is_system, is_legal, wait_hit;
    logic       i_mem_req, ir_write, d_mem_req, mem_write, pc_write, reg_write;

    assign opcode    = bus_io.opcode;
    assign funct3    = bus_io.funct3;
    assign i_rdy     = bus_io.i_mem_ready;
    assign d_rdy     = bus_io.d_mem_ready;
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_system = (opcode == OpSystem);
    assign is_legal  = (opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpR) ||
                       (opcode == OpI) || is_load || is_store || is_branch ||
                       (opcode == OpJal) || (opcode == OpJalr);
    assign wait_hit  = TimeoutEn && (wait_q == WaitMax);

    // Static datapath selects: pure opcode/funct3 decode, independent of state.
    always_comb begin
        bus_io.mem_to_reg     = 1'b0;
        bus_io.alu_src1       = 1'b0;
        bus_io.alu_src2       = 1'b0;
        bus_io.branch         = 1'b0;
        bus_io.jump           = 1'b0;
        bus_io.jal_or_jalr    = 1'b0;
        bus_io.concat_control = 3'b000;
        bus_io.be             = 4'b0000;
        case (opcode)
            OpLui, OpAuipc: begin
                bus_io.concat_control = 3'b001;
                bus_io.alu_src2       = 1'b1;
                bus_io.alu_src1       = (opcode == OpAuipc);
            end
            OpI: begin
                bus_io.alu_src2       = 1'b1;
                bus_io.concat_control = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b110 : 3'b011;
            end
            OpLoad: begin
                bus_io.mem_to_reg     = 1'b1;
                bus_io.alu_src2       = 1'b1;
                bus_io.concat_control = 3'b011;
            end
            OpStore: begin
                bus_io.alu_src2       = 1'b1;
                bus_io.concat_control = 3'b101;
            end
            OpBranch: begin
                bus_io.branch         = 1'b1;
                bus_io.concat_control = 3'b100;
            end
            OpJal: begin
                bus_io.jump           = 1'b1;
                bus_io.alu_src1       = 1'b1;
                bus_io.concat_control = 3'b010;
            end
            OpJalr: begin
                bus_io.jump           = 1'b1;
                bus_io.jal_or_jalr    = 1'b1;
                bus_io.alu_src2       = 1'b1;
                bus_io.concat_control = 3'b011;
            end
            default: ;
        endcase
        if (is_load || is_store) begin
            case (funct3)
                3'b000, 3'b100: bus_io.be = 4'b0001;
                3'b001, 3'b101: bus_io.be = 4'b0011;
                3'b010:         bus_io.be = 4'b1111;
                default:        bus_io.be = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        i_mem_req = 1'b0;
        ir_write  = 1'b0;
        d_mem_req = 1'b0;
        mem_write = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        case (state_q)
            StIf: begin
                i_mem_req = 1'b1;
                if (i_rdy) begin
                    ir_write = 1'b1;
                    state_d  = StId;
                end else if (wait_hit) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end
            end
            StId: begin
                if (is_legal) begin
                    state_d = StEx;
                end else if (is_system) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StEx: begin
                if (is_branch) begin
                    pc_write = 1'b1;
                    state_d  = StIf;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                d_mem_req = 1'b1;
                mem_write = is_store;
                if (d_rdy) begin
                    if (is_load) begin
                        state_d = StWb;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = StIf;
                    end
                end else if (wait_hit) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StIf;
            end
            default: ;
        endcase
    end

    // Wait counter restarts whenever the state changes, so it only counts stalls in place.
    always_comb begin
        wait_d = wait_q;
        if ((state_q == StIf && !i_rdy) || (state_q == StMem && !d_rdy)) begin
            wait_d = wait_q + 1'b1;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end
        instr_cnt_d = pc_write ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIf;
            wait_q      <= '0;
            instr_cnt_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            instr_cnt_q <= instr_cnt_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
        end
    end

    // Reset forces IF, which would otherwise request a fetch while reset is still held.
    assign bus_io.i_mem_req = i_mem_req & rst_ni;
    assign bus_io.ir_write  = ir_write & rst_ni;
    assign bus_io.d_mem_req = d_mem_req & rst_ni;
    assign bus_io.mem_write = mem_write & rst_ni;
    assign bus_io.pc_write  = pc_write & rst_ni;
    assign bus_io.reg_write = reg_write & rst_ni;
    assign bus_io.state     = state_q;
    assign bus_io.alu_op    = opcode;
    assign bus_io.halted    = halted_q;
    assign bus_io.illegal   = illegal_q;
    assign bus_io.timeout   = timeout_q;
    assign bus_io.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Cycle-by-cycle scoreboard bench for mc_control_fsm: a small reference model queues the
// expected per-cycle state/strobes/status; each queued cycle is driven and then compared.
module tb_mc_control_fsm;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 3;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_R = 7'b0110011, OP_I = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Strobe vector order: {i_mem_req, ir_write, d_mem_req, mem_write, pc_write, reg_write}
    localparam logic [5:0] S_IMR = 6'b100000, S_IRW = 6'b010000, S_DMR = 6'b001000;
    localparam logic [5:0] S_MW = 6'b000100, S_PCW = 6'b000010, S_RW = 6'b000001;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       ird;
        logic       drd;
        logic [2:0] st;
        logic [5:0] strb;
        logic [2:0] cnt;
        logic [3:0] be;
        logic       br;
        logic [2:0] cc;
        logic [2:0] flg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2:0] m_cnt = 3'd0;
    logic [2:0] m_flg = 3'd0;   // {halted, illegal, timeout}

    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(CW)) bus ();

    mc_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    function automatic logic [3:0] exp_be(input logic [6:0] op, input logic [2:0] f3);
        if (op != OP_LD && op != OP_ST) return 4'b0000;
        if (f3[1:0] == 2'b00) return 4'b0001;
        if (f3[1:0] == 2'b01) return 4'b0011;
        if (f3 == 3'b010) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [2:0] exp_cc(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LUI, OP_AUIPC: return 3'b001;
            OP_I:             return (f3 == 3'b001 || f3 == 3'b101) ? 3'b110 : 3'b011;
            OP_LD, OP_JALR:   return 3'b011;
            OP_ST:            return 3'b101;
            OP_BR:            return 3'b100;
            OP_JAL:           return 3'b010;
            default:          return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic ird,
                        input logic drd, input logic [2:0] st, input logic [5:0] strb);
        exp_t e;
        e = '{op: op, f3: f3, ird: ird, drd: drd, st: st, strb: strb, cnt: m_cnt,
              be: exp_be(op, f3), br: (op == OP_BR), cc: exp_cc(op, f3), flg: m_flg};
        sb_q.push_back(e);
        if ((strb & S_PCW) != 6'b0) m_cnt = m_cnt + 3'd1;
    endtask

    // Legal instruction: iw/dw stall cycles before the fetch/data ready arrives.
    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input int iw,
                               input int dw);
        for (int k = 0; k <= iw; k++) push(op, f3, k == iw, 1'b1, 3'd0, (k == iw) ? (S_IMR | S_IRW) : S_IMR);
        push(op, f3, 1'b1, 1'b1, 3'd1, 6'b0);
        if (op == OP_BR) begin
            push(op, f3, 1'b1, 1'b1, 3'd2, S_PCW);
        end else if (op == OP_LD || op == OP_ST) begin
            push(op, f3, 1'b1, 1'b1, 3'd2, 6'b0);
            for (int k = 0; k <= dw; k++) begin
                push(op, f3, 1'b1, k == dw, 3'd3,
                     S_DMR | ((op == OP_ST) ? S_MW : 6'b0) | ((op == OP_ST && k == dw) ? S_PCW : 6'b0));
            end
            if (op == OP_LD) push(op, f3, 1'b1, 1'b1, 3'd4, S_RW | S_PCW);
        end else begin
            push(op, f3, 1'b1, 1'b1, 3'd2, 6'b0);
            push(op, f3, 1'b1, 1'b1, 3'd4, S_RW | S_PCW);
        end
    endtask

    // Entered and left at a falling edge; each queued cycle is driven then sampled mid-low.
    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.opcode      = e.op;
            bus.funct3      = e.f3;
            bus.i_mem_ready = e.ird;
            bus.d_mem_ready = e.drd;
            #2;
            check("state", 32'(bus.state), 32'(e.st));
            check("strobes", 32'({bus.i_mem_req, bus.ir_write, bus.d_mem_req, bus.mem_write,
                                  bus.pc_write, bus.reg_write}), 32'(e.strb));
            check("instr_cnt", 32'(bus.instr_cnt), 32'(e.cnt));
            check("flags", 32'({bus.halted, bus.illegal, bus.timeout}), 32'(e.flg));
            check("be", 32'(bus.be), 32'(e.be));
            check("branch", 32'(bus.branch), 32'(e.br));
            check("concat", 32'(bus.concat_control), 32'(e.cc));
            check("alu_op", 32'(bus.alu_op), 32'(e.op));
            @(negedge clk);
        end
    endtask

    // Asynchronous reset pulse: checked before any clock edge can intervene.
    task automatic reset_pulse();
        #2;
        bus.i_mem_ready = 1'b1;
        bus.d_mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_strobes", 32'({bus.i_mem_req, bus.ir_write, bus.d_mem_req, bus.mem_write,
                                  bus.pc_write, bus.reg_write}), 32'd0);
        check("rst_flags", 32'({bus.halted, bus.illegal, bus.timeout}), 32'd0);
        check("rst_cnt", 32'(bus.instr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 3'd0;
        m_flg = 3'd0;
    endtask

    initial begin
        bus.opcode      = OP_R;
        bus.funct3      = 3'b000;
        bus.i_mem_ready = 1'b1;
        bus.d_mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("hold_state", 32'(bus.state), 32'd0);
        check("hold_imreq", 32'(bus.i_mem_req), 32'd0);
        check("hold_cnt", 32'(bus.instr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        model_instr(OP_R, 3'b000, 0, 0);      // ADD: 4 cycles
        model_instr(OP_LD, 3'b010, 0, 3);     // LW, ready on the last allowed MEM cycle
        model_instr(OP_ST, 3'b000, 0, 0);     // SB
        model_instr(OP_BR, 3'b000, 0, 0);     // BEQ: 3 cycles
        model_instr(OP_R, 3'b000, 3, 0);      // fetch ready on the last allowed IF cycle
        model_instr(OP_I, 3'b001, 0, 0);      // SLLI
        model_instr(OP_LUI, 3'b000, 1, 0);
        model_instr(OP_JAL, 3'b000, 0, 0);
        model_instr(OP_JALR, 3'b000, 0, 0);   // ninth retirement: count wraps to 1
        drain();
        check("wrap_cnt", 32'(bus.instr_cnt), 32'd1);

        push(OP_SYS, 3'b000, 1'b1, 1'b1, 3'd0, S_IMR | S_IRW);
        push(OP_SYS, 3'b000, 1'b1, 1'b1, 3'd1, 6'b0);
        m_flg = 3'b100;
        for (int k = 0; k < 5; k++) push(OP_SYS, 3'b000, 1'b1, 1'b1, 3'd5, 6'b0);
        drain();
        reset_pulse();

        push(7'b0000000, 3'b000, 1'b1, 1'b1, 3'd0, S_IMR | S_IRW);
        push(7'b0000000, 3'b000, 1'b1, 1'b1, 3'd1, 6'b0);
        m_flg = 3'b010;
        for (int k = 0; k < 20; k++) push(7'b0000000, 3'b000, 1'b1, 1'b1, 3'd6, 6'b0);
        drain();
        reset_pulse();

        for (int k = 0; k < int'(TO); k++) push(OP_R, 3'b000, 1'b0, 1'b0, 3'd0, S_IMR);
        m_flg = 3'b001;
        for (int k = 0; k < 3; k++) push(OP_R, 3'b000, 1'b1, 1'b1, 3'd6, 6'b0);
        drain();
        reset_pulse();

        // Abort a load mid-stall, then show a clean restart.
        push(OP_LD, 3'b001, 1'b1, 1'b0, 3'd0, S_IMR | S_IRW);
        push(OP_LD, 3'b001, 1'b1, 1'b0, 3'd1, 6'b0);
        push(OP_LD, 3'b001, 1'b1, 1'b0, 3'd2, 6'b0);
        push(OP_LD, 3'b001, 1'b1, 1'b0, 3'd3, S_DMR);
        push(OP_LD, 3'b001, 1'b1, 1'b0, 3'd3, S_DMR);
        drain();
        reset_pulse();
        model_instr(OP_AUIPC, 3'b000, 0, 0);
        model_instr(OP_ST, 3'b001, 0, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
